store_sequencer: RTL

Multi-cycle store controller for the memory write path. It sequences sw, sh and sb. Word stores write register B straight to memory. Sub-word stores do a read-modify-write: read the target word, merge the byte or halfword from B into the WC register, then write WC back. It drives the write-data select of the memory write-data mux (0 = WC, 1 = B) plus the memory address, read and write strobes. It sits between the main control FSM and the data memory.

---
 rtl/store_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/store_sequencer.sv
// store_sequencer
//   Multi-cycle store controller for the memory write path (sw / sh / sb).
//   Word stores write register B straight to memory. Sub-word stores read the
//   target word, merge the byte/halfword from B into WC, then write WC back.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   start            store request, sampled only in IDLE
//   store_size       00 word, 01 halfword, 10 byte, 11 illegal
//   addr             byte address of the store
//   b_data           register B value (store source)
//   mem_rdata        memory read data
//   mem_addr         word address to memory (latched addr, [1:0] = 00)
//   mem_rd / mem_wr  memory read / write strobes
//   write_data_ctrl  write-data mux select: 0 = WC, 1 = B
//   wc_data          WC register (merged word)
//   busy             high in every state except IDLE
//   done / err       one-cycle completion / rejection pulses
//
// State table
//   state    | meaning
//   IDLE     | waiting for start; request latched on accept
//   READ     | mem_rd for one cycle, latency counter loaded
//   WAIT     | counting read latency; WC merged on the final cycle
//   WRITE_B  | word store: write B directly
//   WRITE_WC | sub-word store: write merged WC
//   DONE     | done pulse
//   ERR      | err pulse, no memory access

module store_sequencer #(
  parameter int unsigned MEM_RD_LAT = 1  // legal range 1..7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_size,
  input  logic [31:0] addr,
  input  logic [31:0] b_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        write_data_ctrl,
  output logic [31:0] wc_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_RD_LAT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    WAIT     = 3'd2,
    WRITE_B  = 3'd3,
    WRITE_WC = 3'd4,
    DONE     = 3'd5,
    ERR      = 3'd6
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic [1:0]  sizeReg;
  logic [1:0]  laneReg;
  logic [31:0] bReg;
  logic [31:0] memAddrReg;
  logic [31:0] wcReg;
  logic [2:0]  latCnt;
  logic        reqIllegal;

  // Little-endian lane merge; bits outside the selected lane come from memory.
  function automatic logic [31:0] mergeWord(input logic [31:0] rdata,
                                            input logic [31:0] src,
                                            input logic [1:0]  size,
                                            input logic [1:0]  lane);
    logic [31:0] w;
    w = rdata;
    case (size)
      2'b10: w[{lane, 3'b000} +: 8] = src[7:0];
      2'b01: begin
        if (lane[1]) w[31:16] = src[15:0];
        else         w[15:0]  = src[15:0];
      end
      default: w = src;
    endcase
    return w;
  endfunction

  always_comb begin
    reqIllegal = 1'b0;
    case (store_size)
      2'b00:   reqIllegal = (addr[1:0] != 2'b00);
      2'b01:   reqIllegal = addr[0];
      2'b10:   reqIllegal = 1'b0;
      default: reqIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (reqIllegal)               stateNext = ERR;
          else if (store_size == 2'b00) stateNext = WRITE_B;
          else                          stateNext = READ;
        end
      end
      READ:     stateNext = WAIT;
      WAIT:     if (latCnt == 3'd1) stateNext = WRITE_WC;
      WRITE_B:  stateNext = DONE;
      WRITE_WC: stateNext = DONE;
      DONE:     stateNext = IDLE;
      ERR:      stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Strobes decode from the registered state only, so the async reset
  // removes them immediately and no input reaches an output combinationally.
  always_comb begin
    mem_rd          = 1'b0;
    mem_wr          = 1'b0;
    write_data_ctrl = 1'b1;
    done            = 1'b0;
    err             = 1'b0;
    case (state)
      READ: begin
        mem_rd          = 1'b1;
        write_data_ctrl = 1'b0;
      end
      WAIT:     write_data_ctrl = 1'b0;
      WRITE_B:  mem_wr = 1'b1;
      WRITE_WC: begin
        mem_wr          = 1'b1;
        write_data_ctrl = 1'b0;
      end
      DONE:     done = 1'b1;
      ERR:      err  = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (state != IDLE);
  assign mem_addr = memAddrReg;
  assign wc_data  = wcReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sizeReg    <= 2'b00;
      laneReg    <= 2'b00;
      bReg       <= 32'h0;
      memAddrReg <= 32'h0;
      wcReg      <= 32'h0;
      latCnt     <= 3'd0;
    end else begin
      if (state == IDLE && start) begin
        sizeReg    <= store_size;
        laneReg    <= addr[1:0];
        bReg       <= b_data;
        memAddrReg <= {addr[31:2], 2'b00};
      end
      if (state == READ) begin
        latCnt <= LAT_INIT;
      end else if (state == WAIT) begin
        latCnt <= latCnt - 3'd1;
        // mem_rdata is only valid on the last latency edge.
        if (latCnt == 3'd1) wcReg <= mergeWord(mem_rdata, bReg, sizeReg, laneReg);
      end
    end
  end

endmodule
